msg_schedule: RTL and testbench



---
 rtl/msg_schedule_pkg.sv | 27 ++
 rtl/msg_schedule_if.sv | 12 +
 rtl/msg_schedule_small_sigma.sv | 26 ++
 rtl/msg_schedule.sv | 165 ++++++++++++++++
 tb/tb_msg_schedule.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_schedule_pkg.sv
// Shared constants and arithmetic helpers for the SHA-2 message schedule.
// Covers SHA-224/256 (32-bit words carried in [63:32]) and SHA-384/512 (64-bit words).
package msg_schedule_pkg;

  localparam int ROUNDS_256  = 64;
  localparam int ROUNDS_512  = 80;
  localparam int BLOCK_WORDS = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_EXPAND = 2'd2;

  // 32-bit words live in the upper half, so the lower half is forced to zero.
  function automatic logic [63:0] madd_32_64(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input logic        mode64);
    logic [31:0] s32;
    s32 = a[63:32] + b[63:32];
    return mode64 ? (a + b) : {s32, 32'h0};
  endfunction

  function automatic logic [63:0] word_mask(input logic [63:0] d,
                                            input logic        mode64);
    return mode64 ? d : {d[63:32], 32'h0};
  endfunction

endpackage

// File: rtl/msg_schedule_if.sv
// AXI-Stream bundle used for both the padder-side input and the HCU-side output.
interface msg_schedule_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/msg_schedule_small_sigma.sv
// SHA-2 small sigma function; SIGMA1 selects sigma1 over sigma0.
// In 32-bit mode the operand and result occupy [63:32].
module msg_schedule_small_sigma #(
  parameter bit SIGMA1 = 1'b0
) (
  input  logic        mode64,
  input  logic [63:0] x,
  output logic [63:0] y
);
  logic [31:0] x32;
  logic [31:0] y32;
  logic [63:0] y64;

  assign x32 = x[63:32];

  if (SIGMA1) begin : g_sigma1
    assign y32 = {x32[16:0], x32[31:17]} ^ {x32[18:0], x32[31:19]} ^ (x32 >> 10);
    assign y64 = {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  end else begin : g_sigma0
    assign y32 = {x32[6:0], x32[31:7]} ^ {x32[17:0], x32[31:18]} ^ (x32 >> 3);
    assign y64 = {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  end

  assign y = mode64 ? y64 : {y32, 32'h0};

endmodule

// File: rtl/msg_schedule.sv
// SHA-2 message schedule: takes 16-word padded blocks and streams W_0..W_{N-1}
// to the HCU through a single output register with full-throughput backpressure.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a message; latches sha_type when a word shows up
// ST_LOAD   | passing block words W_0..W_15 through and filling the window
// ST_EXPAND | generating W_16..W_{N-1} from the window, no input accepted
module msg_schedule
  import msg_schedule_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                axi_aclk,
  input  logic                reset,
  input  logic [1:0]          sha_type,
  msg_schedule_if.slave       s_axis,
  msg_schedule_if.master      m_axis,
  output logic                busy,
  output logic                err
);

  logic [1:0]            state;
  logic [6:0]            t;
  logic [6:0]            t_last_idx;
  logic                  mode64;
  logic                  last_blk;
  logic                  rdy_q;
  logic [DATA_WIDTH-1:0] win [BLOCK_WORDS];

  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic                  m_tvalid_q;
  logic                  m_tlast_q;

  logic                  adv;
  logic                  s_tready;
  logic                  s_hs;
  logic                  m_hs;
  logic                  t_final;
  logic                  win_en;
  logic [DATA_WIDTH-1:0] win_in;
  logic [DATA_WIDTH-1:0] s_word;
  logic [DATA_WIDTH-1:0] sig0;
  logic [DATA_WIDTH-1:0] sig1;
  logic [DATA_WIDTH-1:0] w_new;
  logic                  unused_sha_type;

  assign unused_sha_type = sha_type[0];

  assign adv        = !m_tvalid_q || m_axis.tready;
  assign m_hs       = m_tvalid_q && m_axis.tready;
  assign s_hs       = s_axis.tvalid && s_tready;
  assign t_last_idx = mode64 ? 7'(ROUNDS_512 - 1) : 7'(ROUNDS_256 - 1);
  assign t_final    = (t == t_last_idx);
  assign s_word     = word_mask(s_axis.tdata, mode64);

  // In IDLE tready drops while a word is offered so the first word is
  // never handshaken there; LOAD takes it on the following cycle.
  always_comb begin
    s_tready = 1'b0;
    case (state)
      ST_IDLE: s_tready = rdy_q && !s_axis.tvalid;
      ST_LOAD: s_tready = adv;
      default: s_tready = 1'b0;
    endcase
  end

  msg_schedule_small_sigma #(.SIGMA1(1'b0)) u_sigma0 (
    .mode64 (mode64),
    .x      (win[1]),
    .y      (sig0)
  );

  msg_schedule_small_sigma #(.SIGMA1(1'b1)) u_sigma1 (
    .mode64 (mode64),
    .x      (win[14]),
    .y      (sig1)
  );

  // win[15] = W[t-1], win[14] = W[t-2], win[9] = W[t-7], win[1] = W[t-15], win[0] = W[t-16]
  assign w_new = madd_32_64(madd_32_64(sig1, win[9], mode64),
                            madd_32_64(sig0, win[0], mode64), mode64);

  assign win_en = s_hs || ((state == ST_EXPAND) && adv);
  assign win_in = (state == ST_EXPAND) ? w_new : s_word;

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      for (int i = 0; i < BLOCK_WORDS; i++) win[i] <= '0;
    end else if (win_en) begin
      for (int i = 0; i < BLOCK_WORDS - 1; i++) win[i] <= win[i+1];
      win[BLOCK_WORDS-1] <= win_in;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      state      <= ST_IDLE;
      t          <= '0;
      mode64     <= 1'b0;
      last_blk   <= 1'b0;
      rdy_q      <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rdy_q <= 1'b1;

      if (m_hs && m_tlast_q) busy <= 1'b0;
      if (s_hs)              busy <= 1'b1;

      if (adv) begin
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (rdy_q && s_axis.tvalid) begin
            state  <= ST_LOAD;
            mode64 <= sha_type[1];
            t      <= '0;
          end
        end

        ST_LOAD: begin
          if (s_hs) begin
            m_tdata_q  <= s_word;
            m_tvalid_q <= 1'b1;
            t          <= t + 7'd1;
            // An early tlast marks the block as the last one but the
            // remaining words of the block are still collected.
            last_blk   <= (t == 7'd0) ? s_axis.tlast : (last_blk | s_axis.tlast);
            if (s_axis.tlast && (t != 7'(BLOCK_WORDS - 1))) err <= 1'b1;
            if (t == 7'(BLOCK_WORDS - 1)) state <= ST_EXPAND;
          end
        end

        ST_EXPAND: begin
          if (adv) begin
            m_tdata_q  <= w_new;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= t_final && last_blk;
            if (t_final) begin
              t     <= '0;
              state <= last_blk ? ST_IDLE : ST_LOAD;
            end else begin
              t <= t + 7'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis.tready = s_tready;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tlast  = m_tlast_q;

endmodule

// File: tb/tb_msg_schedule.sv
// Bench for msg_schedule: scenario table driven through a reference-model scoreboard,
// plus hand sequences for reset behaviour and mid-expansion reset.
module tb_msg_schedule;
  import msg_schedule_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    bit          m64;
    bit          abc;
    int          nblk;
    int          tlast_word;
    bit          stall;
    logic [63:0] seed;
    int          exp_outs;
    bit          chk_w;
    logic [63:0] w16;
    logic [63:0] w17;
    int          ref_role;   // 0 none, 1 save as reference, 2 compare with reference
  } scen_t;

  logic        axi_aclk = 1'b0;
  logic        reset    = 1'b1;
  logic [1:0]  sha_type = 2'b00;
  logic        busy;
  logic        err;

  msg_schedule_if #(.DATA_WIDTH(64)) s_if ();
  msg_schedule_if #(.DATA_WIDTH(64)) m_if ();

  msg_schedule #(.DATA_WIDTH(64)) dut (
    .axi_aclk (axi_aclk),
    .reset    (reset),
    .sha_type (sha_type),
    .s_axis   (s_if),
    .m_axis   (m_if),
    .busy     (busy),
    .err      (err)
  );

  always #5 axi_aclk = ~axi_aclk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          out_cnt = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  bit          stall_mode = 1'b0;
  bit          err_exp = 1'b0;
  exp_t        exp_q [$];
  logic [63:0] got [$];
  logic [63:0] ref_got [$];
  logic [63:0] blk [16];
  scen_t       tbl [7];

  always @(posedge axi_aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference expansion of the block in blk[], pushed to the scoreboard.
  function automatic void model_block(input bit m64, input bit last);
    logic [63:0] w [80];
    logic [31:0] s32;
    int n;
    n = m64 ? 80 : 64;
    for (int i = 0; i < 16; i++) w[i] = m64 ? blk[i] : {blk[i][63:32], 32'h0};
    for (int i = 16; i < n; i++) begin
      if (m64) begin
        w[i] = (r64(w[i-2], 19) ^ r64(w[i-2], 61) ^ (w[i-2] >> 6)) + w[i-7]
             + (r64(w[i-15], 1) ^ r64(w[i-15], 8) ^ (w[i-15] >> 7)) + w[i-16];
      end else begin
        s32 = (r32(w[i-2][63:32], 17) ^ r32(w[i-2][63:32], 19) ^ (w[i-2][63:32] >> 10))
            + w[i-7][63:32]
            + (r32(w[i-15][63:32], 7) ^ r32(w[i-15][63:32], 18) ^ (w[i-15][63:32] >> 3))
            + w[i-16][63:32];
        w[i] = {s32, 32'h0};
      end
    end
    for (int i = 0; i < n; i++) exp_q.push_back('{data: w[i], last: last && (i == n - 1)});
  endfunction

  function automatic scen_t mk(input bit m64, input bit abc, input int nblk, input int tlw,
                               input bit stall, input logic [63:0] seed, input bit chk_w,
                               input logic [63:0] w16, input logic [63:0] w17, input int role);
    scen_t s;
    s.m64 = m64; s.abc = abc; s.nblk = nblk; s.tlast_word = tlw; s.stall = stall;
    s.seed = seed; s.exp_outs = nblk * (m64 ? 80 : 64); s.chk_w = chk_w;
    s.w16 = w16; s.w17 = w17; s.ref_role = role;
    return s;
  endfunction

  task automatic send_word(input logic [63:0] d, input bit last, input bit gaps);
    bit done;
    if (gaps) begin
      s_if.tvalid = 1'b0;
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
        @(posedge axi_aclk); #1;
      end
    end
    s_if.tdata  = d;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge axi_aclk);
      done = s_if.tready;
      @(posedge axi_aclk); #1;
    end
    check("s_handshake", 64'(done), 64'd1);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic fill_abc(input bit m64);
    for (int i = 0; i < 16; i++) blk[i] = 64'h0;
    blk[0]  = 64'h61626380_00000000;
    blk[15] = m64 ? 64'h00000000_00000018 : 64'h00000018_00000000;
  endtask

  task automatic wait_outputs(input int n);
    for (int k = 0; k < 4000 && (out_cnt < n || exp_q.size() != 0); k++) @(posedge axi_aclk);
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
  endtask

  task automatic run_scen(input scen_t s);
    logic [63:0] x;
    int mism;
    x = s.seed;
    out_cnt = 0;
    got.delete();
    stall_mode = s.stall;
    sha_type = s.m64 ? 2'b10 : 2'b01;
    for (int b = 0; b < s.nblk; b++) begin
      if (s.abc) fill_abc(s.m64);
      else begin
        for (int i = 0; i < 16; i++) begin
          x = x * 64'd6364136223846793005 + 64'd1442695040888963407;
          blk[i] = x;
        end
      end
      model_block(s.m64, b == s.nblk - 1);
      for (int i = 0; i < 16; i++) begin
        send_word(blk[i], (b == s.nblk - 1) && (i == s.tlast_word), s.stall);
        if (b == 0 && i == 0) sha_type = s.m64 ? 2'b01 : 2'b10;
      end
    end
    wait_outputs(s.exp_outs);
    stall_mode = 1'b0;
    if (s.tlast_word != 15) err_exp = 1'b1;
    check("out_count", 64'(out_cnt), 64'(s.exp_outs));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("busy_after", 64'(busy), 64'(0));
    check("err_flag", 64'(err), 64'(err_exp));
    if (!s.stall) check("no_bubble", 64'(last_cyc - first_cyc), 64'(s.exp_outs - 1));
    if (s.chk_w) begin
      check("w16", (got.size() > 16) ? got[16] : 64'hx, s.w16);
      check("w17", (got.size() > 17) ? got[17] : 64'hx, s.w17);
    end
    if (s.ref_role == 1) ref_got = got;
    if (s.ref_role == 2) begin
      mism = 0;
      for (int i = 0; i < got.size(); i++)
        if (i >= ref_got.size() || got[i] !== ref_got[i]) mism++;
      check("match_zero_stall", 64'(mism), 64'd0);
      check("ref_len", 64'(got.size()), 64'(ref_got.size()));
    end
  endtask

  // Output monitor: scoreboard compare and stall-hold checking.
  initial begin
    logic [63:0] hold_d;
    logic        hold_l;
    bit          held;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge axi_aclk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", 64'(m_if.tvalid), 64'd1);
          check("hold_data", m_if.tdata, hold_d);
          check("hold_last", 64'(m_if.tlast), 64'(hold_l));
        end
        held   = m_if.tvalid && !m_if.tready;
        hold_d = m_if.tdata;
        hold_l = m_if.tlast;
        if (m_if.tvalid && m_if.tready) begin
          if (out_cnt == 0) first_cyc = cyc;
          last_cyc = cyc;
          out_cnt++;
          got.push_back(m_if.tdata);
          check("busy_during", 64'(busy), 64'd1);
          check("out_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("w_data", m_if.tdata, e.data);
            check("w_last", 64'(m_if.tlast), 64'(e.last));
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge axi_aclk); #1;
      m_if.tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = 64'h0;
    m_if.tready = 1'b1;

    tbl[0] = mk(1'b0, 1'b1, 1, 15, 1'b0, 64'd0, 1'b1, 64'h61626380_00000000, 64'h000F0000_00000000, 0);
    tbl[1] = mk(1'b1, 1'b1, 1, 15, 1'b0, 64'd0, 1'b1, 64'h61626380_00000000, 64'h00030000_000000C0, 0);
    tbl[2] = mk(1'b0, 1'b0, 2, 15, 1'b0, 64'd11, 1'b0, 64'h0, 64'h0, 0);
    tbl[3] = mk(1'b1, 1'b0, 2, 15, 1'b0, 64'd22, 1'b0, 64'h0, 64'h0, 1);
    tbl[4] = mk(1'b1, 1'b0, 2, 15, 1'b1, 64'd22, 1'b0, 64'h0, 64'h0, 2);
    tbl[5] = mk(1'b0, 1'b1, 1, 9,  1'b0, 64'd0, 1'b1, 64'h61626380_00000000, 64'h000F0000_00000000, 0);
    tbl[6] = mk(1'b0, 1'b0, 1, 15, 1'b1, 64'd33, 1'b0, 64'h0, 64'h0, 0);

    repeat (3) @(posedge axi_aclk);
    #1 reset = 1'b0;
    @(negedge axi_aclk);
    check("rst_s_tready", 64'(s_if.tready), 64'd0);
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_if.tlast), 64'd0);
    check("rst_m_tdata", m_if.tdata, 64'h0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge axi_aclk);
    check("idle_s_tready", 64'(s_if.tready), 64'd1);

    for (int i = 0; i < 7; i++) run_scen(tbl[i]);

    // Reset in the middle of expansion, then a clean message.
    out_cnt = 0;
    got.delete();
    fill_abc(1'b0);
    sha_type = 2'b00;
    model_block(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) send_word(blk[i], i == 15, 1'b0);
    for (int k = 0; k < 500 && out_cnt < 30; k++) @(negedge axi_aclk);
    check("reached_t30", 64'(out_cnt >= 30), 64'd1);
    @(posedge axi_aclk); #1 reset = 1'b1;
    @(posedge axi_aclk); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge axi_aclk);
    check("mid_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("mid_rst_s_tready", 64'(s_if.tready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    err_exp = 1'b0;
    run_scen(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
